smbus_reg_ctrl: RTL

Register-bank controller behind the SMBus/I2C slave in the SMBUS_IOEXP path. It turns the slave's byte-level strobes (OFFSET, DATA_OUT, WRITE_EN, READ_EN, START, STOP) into addressed register accesses with auto-incrementing pointer, and supplies DATA_IN for host reads. It also shares the single bank write port between the SMBus host and local CPLD logic through a req/ack handshake, with the host side at fixed priority.

---
 rtl/smbus_reg_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/smbus_reg_ctrl.sv
// Register-bank controller behind an SMBus slave: turns byte strobes into
// auto-incrementing register accesses and arbitrates the bank write port with local logic.
module smbus_reg_ctrl #(
  parameter int                      NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0]     RO_MASK  = '0,
  parameter logic [NUM_REGS*8-1:0]   REG_INIT = '0
) (
  input  logic                       CLK_IN,
  input  logic                       RESET_N,
  input  logic [7:0]                 OFFSET,
  input  logic [7:0]                 DATA_OUT,
  input  logic                       WRITE_EN,
  input  logic                       READ_EN,
  input  logic                       START,
  input  logic                       STOP,
  output logic [7:0]                 DATA_IN,
  input  logic                       LOCAL_REQ,
  input  logic [7:0]                 LOCAL_ADDR,
  input  logic [7:0]                 LOCAL_WDATA,
  output logic                       LOCAL_ACK,
  output logic [NUM_REGS*8-1:0]      REG_BANK,
  output logic                       HOST_WR_STB,
  output logic [7:0]                 HOST_WR_ADDR
);

  localparam int              AW    = $clog2(NUM_REGS);
  localparam logic [8:0]      DEPTH = 9'(NUM_REGS);
  localparam logic [AW-1:0]   LAST  = AW'(NUM_REGS - 1);

  logic [7:0]    bank [NUM_REGS];
  logic [7:0]    ptr_reg;
  logic          first_reg;
  logic [7:0]    data_in_reg;
  logic          ack_reg;
  logic          wr_stb_reg;
  logic [7:0]    wr_addr_reg;

  logic [7:0]    ea;
  logic [AW-1:0] ea_idx;
  logic          ea_in_range;
  logic [7:0]    ptr_next;
  logic          host_wr;
  logic          grant;
  logic          local_in_range;
  logic [AW-1:0] local_idx;

  always_comb begin
    ea             = first_reg ? OFFSET : ptr_reg;
    ea_idx         = ea[AW-1:0];
    ea_in_range    = {1'b0, ea} < DEPTH;
    ptr_next       = (ea_in_range && ea_idx == LAST) ? 8'h00 : ea + 8'd1;
    host_wr        = WRITE_EN && ea_in_range && !RO_MASK[ea_idx];
    // Host strobes own the write port; a local grant also waits out its own ack cycle.
    grant          = LOCAL_REQ && !WRITE_EN && !READ_EN && !ack_reg;
    local_in_range = {1'b0, LOCAL_ADDR} < DEPTH;
    local_idx      = LOCAL_ADDR[AW-1:0];
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_reg     <= 8'h00;
      first_reg   <= 1'b0;
      data_in_reg <= 8'hFF;
      ack_reg     <= 1'b0;
      wr_stb_reg  <= 1'b0;
      wr_addr_reg <= 8'h00;
    end else begin
      if (WRITE_EN || READ_EN)
        ptr_reg <= ptr_next;
      if (STOP)
        first_reg <= 1'b0;
      else if (START)
        first_reg <= 1'b1;
      else if (WRITE_EN || READ_EN)
        first_reg <= 1'b0;
      // A simultaneous read and write is treated as a write only.
      if (READ_EN && !WRITE_EN)
        data_in_reg <= ea_in_range ? bank[ea_idx] : 8'hFF;
      ack_reg    <= grant;
      wr_stb_reg <= host_wr;
      if (host_wr)
        wr_addr_reg <= ea;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++)
        bank[i] <= REG_INIT[8*i +: 8];
    end else if (host_wr) begin
      bank[ea_idx] <= DATA_OUT;
    end else if (grant && local_in_range) begin
      bank[local_idx] <= LOCAL_WDATA;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign REG_BANK[8*gi +: 8] = bank[gi];
    end
  endgenerate

  assign DATA_IN      = data_in_reg;
  assign LOCAL_ACK    = ack_reg;
  assign HOST_WR_STB  = wr_stb_reg;
  assign HOST_WR_ADDR = wr_addr_reg;

endmodule
